long_to_double: RTL and testbench
=================================

LONG_TO_DOUBLE -- requirements
Module: long_to_double

Interface
REQ-001 Parameters: none; widths fixed at 64 bits in and out.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 input_a  input  64  two's-complement signed 64-bit integer operand.
REQ-005 input_a_stb  input  1  upstream asserts while input_a is valid.
REQ-006 input_a_ack  output  1  block ready to accept; a transfer occurs on an edge where input_a_stb and input_a_ack are both 1.
REQ-007 output_z  output  64  IEEE-754 binary64 result.
REQ-008 output_z_stb  output  1  output_z valid; held until accepted.
REQ-009 output_z_ack  input  1  downstream accepts; a transfer occurs on an edge where output_z_stb and output_z_ack are both 1.

Function
REQ-010 The block SHALL be a single FSM with states get_a, convert_0, convert_1, convert_2, round, pack, put_z.
REQ-011 get_a: input_a_ack=1; on transfer, latch input_a, drop input_a_ack at that edge, go to convert_0.
REQ-012 convert_0: if a==0, set z=0x0000000000000000 (+0.0) and go to put_z; else sign=a[63], value=|a| as unsigned 64-bit, exponent=63, go to convert_1.
REQ-013 |a| for a=0x8000000000000000 SHALL be the unsigned value 2^63 (MSB set); no overflow special case.
REQ-014 convert_1: while value[63]==0, shift value left one bit and decrement exponent, one bit per cycle; when value[63]==1, go to convert_2.
REQ-015 convert_2: mantissa m=value[63:11] (53 bits incl. hidden 1), guard=value[10], round_bit=value[9], sticky=OR of value[8:0]; go to round.
REQ-016 round: round-to-nearest-even; increment m if guard && (round_bit || sticky || m[0]); if m was all ones, m becomes 1<<52 and exponent increments; go to pack.
REQ-017 pack: z[63]=sign, z[62:52]=exponent+1023, z[51:0]=m[51:0]; go to put_z.
REQ-018 put_z: output_z_stb=1, output_z=z; on transfer, drop output_z_stb at that edge and go to get_a.
REQ-019 With accepting edge E0 and L leading zeros of |a|, output_z_stb SHALL rise exactly at edge E(L+6) for nonzero a and at E2 for a==0.
REQ-020 input_a_ack SHALL be 0 in every state except get_a; no new operand is accepted while a result is pending.
REQ-021 output_z and output_z_stb SHALL stay stable while output_z_ack is low; stalls of any length are legal.
REQ-022 Every int64 result is exact or rounded; no NaN, infinity or subnormal output is ever produced.

Reset
REQ-023 While rst=1 at an edge: state=get_a, input_a_ack=0, output_z_stb=0, output_z=0; rst overrides any simultaneous handshake.
REQ-024 input_a_ack SHALL rise at the first edge with rst=0; reset mid-conversion discards the operand with no output produced.

Structure
REQ-025 A shared package fpu_pkg SHALL hold the state encodings and constants DOUBLE_BIAS=1023, DOUBLE_MANT_W=52, DOUBLE_EXP_W=11.
REQ-026 No sub-module; a single sequential FSM with registered outputs, target 150-250 lines.

Verification
REQ-027 a=0x0000000000000001 -> z=0x3FF0000000000000, stb at E69; a=0xFFFFFFFFFFFFFFFF -> z=0xBFF0000000000000.
REQ-028 a=0 -> z=0x0000000000000000 with output_z_stb at E2.
REQ-029 a=0x7FFFFFFFFFFFFFFF -> 0x43E0000000000000 (round carry); a=0x8000000000000000 -> 0xC3E0000000000000.
REQ-030 Ties: a=0x0020000000000001 -> 0x4340000000000000; a=0x0020000000000003 -> 0x4340000000000002.
REQ-031 Hold output_z_ack=0 for 10 cycles with input_a_stb=1 -> output_z stable, input_a_ack=0 throughout, one result per operand.
REQ-032 Assert rst during convert_1 -> all outputs 0 next edge, no output_z transfer, next operand converted correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared encodings and binary64 field constants for the integer-to-double converter.
package fpu_pkg;

  localparam int unsigned INT_W         = 64;
  localparam int unsigned DOUBLE_BIAS   = 1023;
  localparam int unsigned DOUBLE_MANT_W = 52;
  localparam int unsigned DOUBLE_EXP_W  = 11;
  localparam int unsigned SIG_W         = DOUBLE_MANT_W + 1;

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT_0 = 3'd1,
    CONVERT_1 = 3'd2,
    CONVERT_2 = 3'd3,
    ROUND     = 3'd4,
    PACK      = 3'd5,
    PUT_Z     = 3'd6
  } l2d_state_e;

endpackage

// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 binary64 converter; one-bit-per-cycle
// normalisation, round-to-nearest-even, valid/ack handshakes on both sides.
module long_to_double
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [INT_W-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  l2d_state_e              state_q, state_d;
  logic [INT_W-1:0]        a_q, a_d;
  logic [INT_W-1:0]        value_q, value_d;
  logic [INT_W-1:0]        z_q, z_d;
  logic [INT_W-1:0]        z_out_q, z_out_d;
  logic [DOUBLE_EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0]        mant_q, mant_d;
  logic                    sign_q, sign_d;
  logic                    guard_q, guard_d;
  logic                    rnd_q, rnd_d;
  logic                    sticky_q, sticky_d;
  logic                    a_ack_q, a_ack_d;
  logic                    z_stb_q, z_stb_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GET_A;
      a_q      <= '0;
      value_q  <= '0;
      z_q      <= '0;
      z_out_q  <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
      sign_q   <= 1'b0;
      guard_q  <= 1'b0;
      rnd_q    <= 1'b0;
      sticky_q <= 1'b0;
      a_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      value_q  <= value_d;
      z_q      <= z_d;
      z_out_q  <= z_out_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sign_q   <= sign_d;
      guard_q  <= guard_d;
      rnd_q    <= rnd_d;
      sticky_q <= sticky_d;
      a_ack_q  <= a_ack_d;
      z_stb_q  <= z_stb_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    value_d  = value_q;
    z_d      = z_q;
    z_out_d  = z_out_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sign_d   = sign_q;
    guard_d  = guard_q;
    rnd_d    = rnd_q;
    sticky_d = sticky_q;
    a_ack_d  = a_ack_q;
    z_stb_d  = z_stb_q;

    unique case (state_q)
      GET_A: begin
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = CONVERT_0;
        end else begin
          a_ack_d = 1'b1;
        end
      end
      CONVERT_0: begin
        if (a_q == '0) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else begin
          sign_d  = a_q[INT_W-1];
          // Negating 0x8000... wraps to itself, which is exactly 2^63 unsigned
          value_d = a_q[INT_W-1] ? (~a_q + INT_W'(1)) : a_q;
          exp_d   = DOUBLE_EXP_W'(INT_W - 1);
          state_d = CONVERT_1;
        end
      end
      CONVERT_1: begin
        if (!value_q[INT_W-1]) begin
          value_d = value_q << 1;
          exp_d   = exp_q - DOUBLE_EXP_W'(1);
        end else begin
          state_d = CONVERT_2;
        end
      end
      CONVERT_2: begin
        mant_d   = value_q[INT_W-1:INT_W-SIG_W];
        guard_d  = value_q[INT_W-SIG_W-1];
        rnd_d    = value_q[INT_W-SIG_W-2];
        sticky_d = |value_q[INT_W-SIG_W-3:0];
        state_d  = ROUND;
      end
      ROUND: begin
        if (guard_q && (rnd_q || sticky_q || mant_q[0])) begin
          if (&mant_q) begin
            mant_d = SIG_W'(1) << DOUBLE_MANT_W;
            exp_d  = exp_q + DOUBLE_EXP_W'(1);
          end else begin
            mant_d = mant_q + SIG_W'(1);
          end
        end
        state_d = PACK;
      end
      PACK: begin
        z_d     = {sign_q, exp_q + DOUBLE_EXP_W'(DOUBLE_BIAS), mant_q[DOUBLE_MANT_W-1:0]};
        state_d = PUT_Z;
      end
      PUT_Z: begin
        // First cycle here only presents the result; acceptance is checked afterwards
        if (!z_stb_q) begin
          z_stb_d = 1'b1;
          z_out_d = z_q;
        end else if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  assign input_a_ack  = a_ack_q;
  assign output_z     = z_out_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_long_to_double.sv
// Scoreboard bench for long_to_double: result value, output latency,
// stall stability, back-pressure on the input side and mid-conversion reset.
module tb_long_to_double;

  typedef struct {
    logic [63:0] z;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_sent = 0;
  int          n_res = 0;
  int          stall_req = 0;

  long_to_double dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_z(input logic [63:0] a);
    longint s;
    real    r;
    s = longint'(a);
    r = s;
    return $realtobits(r);
  endfunction

  function automatic int lat_of(input logic [63:0] a);
    logic [63:0] m;
    int          l;
    if (a == 64'd0) return 2;
    m = a[63] ? (~a + 64'd1) : a;
    l = 0;
    for (int i = 63; i >= 0; i--) begin
      if (m[i]) break;
      l++;
    end
    return l + 6;
  endfunction

  // Called just after a negedge; returns just after the negedge following the transfer
  task automatic send(input logic [63:0] a, input logic [63:0] z, input bit hold);
    int   n;
    exp_t e;
    input_a     = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      check_eq("ack_timeout", 64'(input_a_ack), 64'd1);
    end else begin
      e.z = z;
      e.acc_cyc = cyc + 1;
      e.lat = lat_of(a);
      sb_q.push_back(e);
      n_sent++;
    end
    @(negedge clk);
    if (!hold) input_a_stb = 1'b0;
  endtask

  // Output side: compare on result arrival, hold stable through stalls, then accept
  int          stall = 0;
  bit          have = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      output_z_ack = 1'b0;
      have = 1'b0;
    end else if (output_z_stb) begin
      if (!have) begin
        have = 1'b1;
        held = output_z;
        if (sb_q.size() == 0) begin
          check_eq("spurious_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("z_value", output_z, e.z);
          check_eq("z_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
        stall = (stall_req != 0) ? stall_req : int'($urandom_range(0, 2));
        stall_req = 0;
      end else begin
        check_eq("z_hold", output_z, held);
      end
      check_eq("a_ack_while_pending", 64'(input_a_ack), 64'd0);
      if (stall == 0) begin
        output_z_ack = 1'b1;
        have = 1'b0;
        n_res++;
      end else begin
        output_z_ack = 1'b0;
        stall--;
      end
    end else begin
      output_z_ack = 1'b0;
    end
  end

  initial begin
    logic [63:0] ra;
    int          n;
    rst = 1'b1;
    input_a = '0;
    input_a_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_ack", 64'(input_a_ack), 64'd0);
    check_eq("rst_z_stb", 64'(output_z_stb), 64'd0);
    check_eq("rst_z", output_z, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ack_after_rst", 64'(input_a_ack), 64'd1);

    send(64'h0000000000000001, 64'h3FF0000000000000, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 1'b0);
    send(64'h0000000000000000, 64'h0000000000000000, 1'b0);
    send(64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 1'b0);
    send(64'h8000000000000000, 64'hC3E0000000000000, 1'b0);
    send(64'h0020000000000001, 64'h4340000000000000, 1'b0);
    send(64'h0020000000000003, 64'h4340000000000002, 1'b0);

    // Long stall with the next operand already offered
    stall_req = 10;
    send(64'h0000000000000005, 64'h4014000000000000, 1'b1);
    send(64'hFFFFFFFFFFFFFFFD, 64'hC008000000000000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) ra = ~ra + 64'd1;
      send(ra, model_z(ra), 1'b0);
    end

    // Reset while the operand is still being normalised
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    send(64'h0000000000000001, 64'h3FF0000000000000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    n_sent--;
    @(negedge clk);
    check_eq("midrst_a_ack", 64'(input_a_ack), 64'd0);
    check_eq("midrst_z_stb", 64'(output_z_stb), 64'd0);
    check_eq("midrst_z", output_z, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ack_rise", 64'(input_a_ack), 64'd1);
    send(64'h0020000000000003, 64'h4340000000000002, 1'b0);
    send(64'hFFFFFFFFFFFFFC00, 64'hC090000000000000, 1'b0);

    n = 0;
    while ((sb_q.size() != 0 || output_z_stb) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", 64'(sb_q.size()), 64'd0);
    check_eq("result_count", 64'(n_res), 64'(n_sent));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
